accel_sram_arbiter: RTL and testbench



---
 rtl/accel_sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_accel_sram_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_sram_arbiter.sv
// Shares one single-port SRAM between the host window and the compute engine:
// round-robin arbitration, capped engine burst lock, and read-tag return steering.
module accel_sram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_write,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_rdata,

  input  logic              eng_req_valid,
  output logic              eng_req_ready,
  input  logic              eng_req_write,
  input  logic [ADDR_W-1:0] eng_req_addr,
  input  logic [DATA_W-1:0] eng_req_wdata,
  input  logic              eng_lock,
  output logic              eng_rsp_valid,
  output logic [DATA_W-1:0] eng_rsp_rdata,

  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam logic [0:0] GNT_HOST = 1'b0;
  localparam logic [0:0] GNT_ENG  = 1'b1;
  localparam int         CNT_W    = $clog2(LOCK_MAX + 1);

  logic [0:0]        r_last_grant;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_port;
  logic              r_host_rsp_valid;
  logic              r_eng_rsp_valid;
  logic [DATA_W-1:0] r_host_rsp_rdata;
  logic [DATA_W-1:0] r_eng_rsp_rdata;

  logic              w_lock_active;
  logic              w_host_gnt;
  logic              w_eng_gnt;
  logic              w_any_gnt;
  logic              w_cmd_we;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic [DATA_W-1:0] w_cmd_wdata;
  logic              w_rd_push;
  logic              w_tap_vld;
  logic [0:0]        w_tap_port;

  // Grant decision. Reset gates the grant so every output reads 0 while rst is high.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_host_gnt    = 1'b0;
    w_eng_gnt     = 1'b0;
    w_lock_active = (r_last_grant == GNT_ENG) && eng_lock &&
                    (r_lock_cnt < CNT_W'(LOCK_MAX));
    if (!rst) begin
      if (host_req_valid && eng_req_valid) begin
        if (w_lock_active || (r_last_grant == GNT_HOST)) begin
          w_eng_gnt = 1'b1;
        end else begin
          w_host_gnt = 1'b1;
        end
      end else begin
        w_host_gnt = host_req_valid;
        w_eng_gnt  = eng_req_valid;
      end
    end
  end

  assign w_any_gnt      = w_host_gnt | w_eng_gnt;
  assign host_req_ready = w_host_gnt;
  assign eng_req_ready  = w_eng_gnt;

  always_comb begin
    w_cmd_we    = 1'b0;
    w_cmd_addr  = '0;
    w_cmd_wdata = '0;
    if (w_host_gnt) begin
      w_cmd_we    = host_req_write;
      w_cmd_addr  = host_req_addr;
      w_cmd_wdata = host_req_wdata;
    end else if (w_eng_gnt) begin
      w_cmd_we    = eng_req_write;
      w_cmd_addr  = eng_req_addr;
      w_cmd_wdata = eng_req_wdata;
    end
  end

  assign sram_en    = w_any_gnt;
  assign sram_we    = w_cmd_we;
  assign sram_addr  = w_cmd_addr;
  assign sram_wdata = w_cmd_wdata;

  // Round-robin pointer and burst-lock counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
      r_last_grant <= GNT_ENG;
      r_lock_cnt   <= '0;
    end else begin
      if (w_host_gnt) begin
        r_last_grant <= GNT_HOST;
      end else if (w_eng_gnt) begin
        r_last_grant <= GNT_ENG;
      end

      if (w_host_gnt || !eng_lock) begin
        r_lock_cnt <= '0;
      end else if (w_eng_gnt && host_req_valid && w_lock_active) begin
        r_lock_cnt <= r_lock_cnt + CNT_W'(1);
      end
    end
  end

  assign w_rd_push  = w_any_gnt && !w_cmd_we;
  assign w_tap_vld  = r_tag_vld[RD_LAT-1];
  assign w_tap_port = r_tag_port[RD_LAT-1];

  // Tag pipeline tracks the SRAM read latency; stage RD_LAT-1 lines up with sram_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= '0;
      r_tag_port <= '0;
    end else begin
      r_tag_vld[0]  <= w_rd_push;
      r_tag_port[0] <= w_eng_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_port[i] <= r_tag_port[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_rsp_valid <= 1'b0;
      r_eng_rsp_valid  <= 1'b0;
      r_host_rsp_rdata <= '0;
      r_eng_rsp_rdata  <= '0;
    end else begin
      r_host_rsp_valid <= w_tap_vld && (w_tap_port == GNT_HOST);
      r_eng_rsp_valid  <= w_tap_vld && (w_tap_port == GNT_ENG);
      if (w_tap_vld && (w_tap_port == GNT_HOST)) begin
        r_host_rsp_rdata <= sram_rdata;
      end
      if (w_tap_vld && (w_tap_port == GNT_ENG)) begin
        r_eng_rsp_rdata <= sram_rdata;
      end
    end
  end

  assign host_rsp_valid = r_host_rsp_valid;
  assign host_rsp_rdata = r_host_rsp_rdata;
  assign eng_rsp_valid  = r_eng_rsp_valid;
  assign eng_rsp_rdata  = r_eng_rsp_rdata;

  a_one_ready : assert property (@(posedge clk) disable iff (rst)
    !(host_req_ready && eng_req_ready));
  a_one_rsp : assert property (@(posedge clk) disable iff (rst)
    !(host_rsp_valid && eng_rsp_valid));

endmodule

// File: tb/tb_accel_sram_arbiter.sv
// Drives two arbiter instances (RD_LAT 1 and 3) with shared stimulus and checks
// both against a transaction-level model of arbitration, SRAM contents and responses.
module tb_accel_sram_arbiter;

  localparam int AW       = 13;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 16;
  localparam int DEPTH    = 1 << AW;

  typedef struct {
    int         issue;
    bit         port;     // 0 host, 1 engine
    logic [31:0] data;
  } rsp_t;

  logic clk;
  logic rst;
  logic mem_init;

  logic          host_req_valid, host_req_write;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_wdata;
  logic          eng_req_valid, eng_req_write, eng_lock;
  logic [AW-1:0] eng_req_addr;
  logic [DW-1:0] eng_req_wdata;

  logic          h_rdy [2];
  logic          e_rdy [2];
  logic          h_rv  [2];
  logic          e_rv  [2];
  logic [DW-1:0] h_rd  [2];
  logic [DW-1:0] e_rd  [2];
  logic          s_en  [2];
  logic          s_we  [2];
  logic [AW-1:0] s_addr[2];
  logic [DW-1:0] s_wd  [2];
  logic [DW-1:0] s_rd  [2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] pat(input int a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  accel_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .LOCK_MAX(LOCK_MAX)) u_dut1 (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(h_rdy[0]), .host_req_write(host_req_write),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(h_rv[0]), .host_rsp_rdata(h_rd[0]),
    .eng_req_valid(eng_req_valid), .eng_req_ready(e_rdy[0]), .eng_req_write(eng_req_write),
    .eng_req_addr(eng_req_addr), .eng_req_wdata(eng_req_wdata), .eng_lock(eng_lock),
    .eng_rsp_valid(e_rv[0]), .eng_rsp_rdata(e_rd[0]),
    .sram_en(s_en[0]), .sram_we(s_we[0]), .sram_addr(s_addr[0]), .sram_wdata(s_wd[0]),
    .sram_rdata(s_rd[0])
  );

  accel_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .LOCK_MAX(LOCK_MAX)) u_dut3 (
    .clk(clk), .rst(rst),
    .host_req_valid(host_req_valid), .host_req_ready(h_rdy[1]), .host_req_write(host_req_write),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_rsp_valid(h_rv[1]), .host_rsp_rdata(h_rd[1]),
    .eng_req_valid(eng_req_valid), .eng_req_ready(e_rdy[1]), .eng_req_write(eng_req_write),
    .eng_req_addr(eng_req_addr), .eng_req_wdata(eng_req_wdata), .eng_lock(eng_lock),
    .eng_rsp_valid(e_rv[1]), .eng_rsp_rdata(e_rd[1]),
    .sram_en(s_en[1]), .sram_we(s_we[1]), .sram_addr(s_addr[1]), .sram_wdata(s_wd[1]),
    .sram_rdata(s_rd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro models: RD_LAT 1 and RD_LAT 3 read pipelines.
  logic [31:0] mem0 [DEPTH];
  logic [31:0] mem1 [DEPTH];
  logic [31:0] p0;
  logic [31:0] p1 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem0[i] <= pat(i);
      p0 <= '0;
    end else begin
      if (s_en[0] && s_we[0]) mem0[s_addr[0]] <= s_wd[0];
      p0 <= (s_en[0] && !s_we[0]) ? mem0[s_addr[0]] : 32'h0;
    end
  end
  assign s_rd[0] = p0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem1[i] <= pat(i);
      for (int i = 0; i < 3; i++) p1[i] <= '0;
    end else begin
      if (s_en[1] && s_we[1]) mem1[s_addr[1]] <= s_wd[1];
      p1[0] <= (s_en[1] && !s_we[1]) ? mem1[s_addr[1]] : 32'h0;
      p1[1] <= p1[0];
      p1[2] <= p1[1];
    end
  end
  assign s_rd[1] = p1[2];

  // Reference model: arbitration rules, memory image and expected response stream.
  logic [31:0] m_mem [DEPTH];
  bit          m_last_eng;
  int          m_cnt;
  bit          m_gh, m_ge;
  rsp_t        rq[$];
  int          ridx [2];
  logic [31:0] exp_hd [2];
  logic [31:0] exp_ed [2];
  int          cyc = 0;

  always @(negedge clk) begin
    bit lk, exp_hv, exp_ev, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    cyc++;
    if (mem_init) for (int i = 0; i < DEPTH; i++) m_mem[i] = pat(i);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d.rst_ctl", d),
              64'({h_rdy[d], e_rdy[d], h_rv[d], e_rv[d], s_en[d], s_we[d]}), 64'(0));
        check($sformatf("d%0d.rst_data", d),
              64'(h_rd[d] | e_rd[d] | s_wd[d] | 32'(s_addr[d])), 64'(0));
        exp_hd[d] = '0;
        exp_ed[d] = '0;
        ridx[d]   = 0;
      end
      rq.delete();
      m_last_eng = 1'b1;
      m_cnt      = 0;
      m_gh       = 1'b0;
      m_ge       = 1'b0;
    end else begin
      lk   = m_last_eng && eng_lock && (m_cnt < LOCK_MAX);
      m_gh = host_req_valid && (!eng_req_valid || (!lk && m_last_eng));
      m_ge = eng_req_valid && (!host_req_valid || lk || !m_last_eng);
      exp_we   = m_gh ? host_req_write : (m_ge ? eng_req_write : 1'b0);
      exp_addr = m_gh ? host_req_addr  : (m_ge ? eng_req_addr  : '0);
      exp_wd   = m_gh ? host_req_wdata : (m_ge ? eng_req_wdata : '0);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d.host_ready", d), 64'(h_rdy[d]), 64'(m_gh));
        check($sformatf("d%0d.eng_ready", d), 64'(e_rdy[d]), 64'(m_ge));
        check($sformatf("d%0d.sram_en", d), 64'(s_en[d]), 64'(m_gh | m_ge));
        check($sformatf("d%0d.sram_we", d), 64'(s_we[d]), 64'(exp_we));
        check($sformatf("d%0d.sram_addr", d), 64'(s_addr[d]), 64'(exp_addr));
        check($sformatf("d%0d.sram_wdata", d), 64'(s_wd[d]), 64'(exp_wd));
        exp_hv = 1'b0;
        exp_ev = 1'b0;
        if (ridx[d] < rq.size() && rq[ridx[d]].issue + lat(d) + 1 == cyc) begin
          if (rq[ridx[d]].port) begin
            exp_ev    = 1'b1;
            exp_ed[d] = rq[ridx[d]].data;
          end else begin
            exp_hv    = 1'b1;
            exp_hd[d] = rq[ridx[d]].data;
          end
          ridx[d]++;
        end
        check($sformatf("d%0d.host_rsp_valid", d), 64'(h_rv[d]), 64'(exp_hv));
        check($sformatf("d%0d.eng_rsp_valid", d), 64'(e_rv[d]), 64'(exp_ev));
        check($sformatf("d%0d.host_rsp_rdata", d), 64'(h_rd[d]), 64'(exp_hd[d]));
        check($sformatf("d%0d.eng_rsp_rdata", d), 64'(e_rd[d]), 64'(exp_ed[d]));
      end
      if ((m_gh || m_ge) && !exp_we) rq.push_back('{cyc, m_ge, m_mem[exp_addr]});
      if ((m_gh || m_ge) && exp_we) m_mem[exp_addr] = exp_wd;
      if (m_gh) m_last_eng = 1'b0;
      else if (m_ge) m_last_eng = 1'b1;
      if (m_gh || !eng_lock) m_cnt = 0;
      else if (m_ge && host_req_valid && lk) m_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_req_valid = 0; host_req_write = 0; host_req_addr = '0; host_req_wdata = '0;
    eng_req_valid  = 0; eng_req_write  = 0; eng_req_addr  = '0; eng_req_wdata  = '0;
    eng_lock       = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic set_host(input bit v, input bit w, input int a, input logic [31:0] wd);
    host_req_valid = v; host_req_write = w; host_req_addr = AW'(a); host_req_wdata = wd;
  endtask

  task automatic set_eng(input bit v, input bit w, input int a, input logic [31:0] wd);
    eng_req_valid = v; eng_req_write = w; eng_req_addr = AW'(a); eng_req_wdata = wd;
  endtask

  initial begin
    rst = 1;
    mem_init = 1;
    idle();
    repeat (2) step();
    mem_init = 0;
    rst = 0;

    // Host write then read of 0x010, no wait states, response two cycles later.
    set_host(1, 1, 'h010, 32'hDEAD_BEEF);
    #2 check("t1.wr_ready", 64'(h_rdy[0]), 64'(1));
    check("t1.wr_we", 64'(s_we[0]), 64'(1));
    step();
    set_host(1, 0, 'h010, 32'h0);
    #2 check("t1.rd_ready", 64'(h_rdy[0]), 64'(1));
    check("t1.rd_we", 64'(s_we[0]), 64'(0));
    step();
    idle();
    #2 check("t1.rsp_early", 64'(h_rv[0]), 64'(0));
    step();
    #2 check("t1.rsp_valid", 64'(h_rv[0]), 64'(1));
    check("t1.rsp_data", 64'(h_rd[0]), 64'(32'hDEAD_BEEF));
    check("t1.eng_rsp", 64'(e_rv[0]), 64'(0));
    step();

    // Continuous reads from both ports without lock alternate, host first.
    do_reset();
    set_host(1, 0, 'h001, 32'h0);
    set_eng(1, 0, 'h100, 32'h0);
    for (int k = 0; k < 8; k++) begin
      #2 check($sformatf("t2.host_gnt%0d", k), 64'(h_rdy[0]), 64'((k % 2) == 0));
      check($sformatf("t2.eng_gnt%0d", k), 64'(e_rdy[0]), 64'((k % 2) == 1));
      if (k >= 2) begin
        if ((k % 2) == 0) begin
          check($sformatf("t2.host_rsp%0d", k), 64'({h_rv[0], h_rd[0]}), {31'b0, 1'b1, pat('h001)});
        end else begin
          check($sformatf("t2.eng_rsp%0d", k), 64'({e_rv[0], e_rd[0]}), {31'b0, 1'b1, pat('h100)});
        end
      end
      step();
    end
    idle();
    repeat (5) step();

    // Engine lock with both ports busy: 16 engine grants, one host, then engine again.
    do_reset();
    set_host(1, 0, 'h020, 32'h0);
    set_eng(1, 0, 'h120, 32'h0);
    eng_lock = 1;
    for (int k = 0; k < 20; k++) begin
      #2 check($sformatf("t3.eng_gnt%0d", k), 64'(e_rdy[0]), 64'(k != 16));
      step();
    end
    idle();
    repeat (5) step();

    // Reset while an engine read is in flight drops the response.
    do_reset();
    set_eng(1, 0, 'h055, 32'h0);
    #2 check("t4.eng_gnt", 64'(e_rdy[0]), 64'(1));
    step();
    idle();
    rst = 1;
    #2 check("t4.rst_outs", 64'({e_rv[0], e_rv[1], h_rdy[0], e_rdy[0], s_en[0]}), 64'(0));
    step();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      #2 check($sformatf("t4.no_rsp%0d", k), 64'({e_rv[0], e_rv[1]}), 64'(0));
      step();
    end
    set_host(1, 0, 'h056, 32'h0);
    set_eng(1, 0, 'h057, 32'h0);
    #2 check("t4.host_first", 64'({h_rdy[0], e_rdy[0]}), 64'(2'b10));
    step();
    idle();
    repeat (5) step();

    // RD_LAT=3 instance: H,E,H reads return four cycles after each handshake.
    do_reset();
    set_host(1, 0, 'h2, 32'h0);
    step();
    set_host(0, 0, 0, 32'h0);
    set_eng(1, 0, 'h3, 32'h0);
    step();
    set_eng(0, 0, 0, 32'h0);
    set_host(1, 0, 'h4, 32'h0);
    step();
    idle();
    step();
    #2 check("t5.h2", 64'({h_rv[1], e_rv[1], h_rd[1]}), {30'b0, 2'b10, pat('h2)});
    step();
    #2 check("t5.e3", 64'({h_rv[1], e_rv[1], e_rd[1]}), {30'b0, 2'b01, pat('h3)});
    step();
    #2 check("t5.h4", 64'({h_rv[1], e_rv[1], h_rd[1]}), {30'b0, 2'b10, pat('h4)});
    step();
    repeat (3) step();

    // Host drops its request while the engine holds the lock.
    do_reset();
    set_eng(1, 0, 'h0C0, 32'h0);
    eng_lock = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) set_host(1, 1, 'h0AA, 32'h1111_2222);
      if (k == 3) set_host(0, 0, 0, 32'h0);
      #2 check($sformatf("t6.cycle%0d", k), 64'({h_rdy[0], e_rdy[0], s_addr[0]}), {49'b0, 2'b01, 13'h0C0});
      step();
    end
    idle();
    repeat (5) step();

    // Randomized traffic with holds, drops, lock toggling and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1;
        step();
        rst = 0;
      end
      if (!host_req_valid || m_gh) begin
        set_host($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 31)), $urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        host_req_valid = 0;
      end
      if (!eng_req_valid || m_ge) begin
        set_eng($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 31)), $urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        eng_req_valid = 0;
      end
      if ($urandom_range(0, 24) == 0) eng_lock = ~eng_lock;
      step();
    end
    idle();
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
